io_bridge_wide_to_narrow_fta: RTL and testbench

//  Parametrised FTA I/O bridge: one WID-bit CPU-side slave port, one NWID-bit master port to I/O devices.

---
 rtl/fta_bus_pkg.sv | 67 ++++++
 rtl/fta_respbuf.sv | 19 +
 rtl/io_bridge_wide_to_narrow_fta.sv | 192 +++++++++++++++++++
 tb/tb_io_bridge_wide_to_narrow_fta.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fta_bus_pkg.sv
// FTA bus types shared by the wide-to-narrow bridge: request/response structs for the
// 128-bit CPU side and the 32-bit device side, plus the bridge FSM state encoding.
package fta_bus_pkg;

  localparam int SWID = 128;
  localparam int MWID = 32;
  localparam int TIDW = 8;
  localparam int AW   = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } bridge_state_t;

  typedef struct packed {
    logic            cyc;
    logic            stb;
    logic            we;
    logic [4:0]      cmd;
    logic [1:0]      bte;
    logic [2:0]      cti;
    logic [TIDW-1:0] tid;
    logic [AW-1:0]   padr;
    logic [SWID/8-1:0] sel;
    logic [SWID-1:0] data1;
  } fta_cmd_request128_t;

  typedef struct packed {
    logic            cyc;
    logic            stb;
    logic            we;
    logic [4:0]      cmd;
    logic [1:0]      bte;
    logic [2:0]      cti;
    logic [TIDW-1:0] tid;
    logic [AW-1:0]   padr;
    logic [MWID/8-1:0] sel;
    logic [MWID-1:0] data1;
  } fta_cmd_request32_t;

  typedef struct packed {
    logic            ack;
    logic            err;
    logic            rty;
    logic            next;
    logic            stall;
    logic [SWID-1:0] dat;
    logic [TIDW-1:0] tid;
    logic [AW-1:0]   adr;
    logic [3:0]      pri;
  } fta_cmd_response128_t;

  typedef struct packed {
    logic            ack;
    logic            err;
    logic            rty;
    logic            next;
    logic            stall;
    logic [MWID-1:0] dat;
    logic [TIDW-1:0] tid;
    logic [AW-1:0]   adr;
    logic [3:0]      pri;
  } fta_cmd_response32_t;

endpackage

// File: rtl/fta_respbuf.sv
// Merges the per-channel device responses into one response stream; when several
// channels respond in the same cycle the lowest-numbered channel is taken.
module fta_respbuf
  import fta_bus_pkg::*;
#(
  parameter int CHANNELS = 2
) (
  input  fta_cmd_response32_t chresp [CHANNELS],
  output fta_cmd_response32_t respo
);

  always_comb begin
    respo = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (chresp[c].ack || chresp[c].err || chresp[c].rty) respo = chresp[c];
    end
  end

endmodule

// File: rtl/io_bridge_wide_to_narrow_fta.sv
// Wide-to-narrow FTA I/O bridge: splits a multi-lane CPU request into sequential
// device beats and merges the lane responses back into a single CPU response.
module io_bridge_wide_to_narrow_fta
  import fta_bus_pkg::*;
#(
  parameter int WID      = SWID,
  parameter int NWID     = MWID,
  parameter int CHANNELS = 2,
  parameter int TMO      = 1023
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  fta_cmd_request128_t  s_req,
  output fta_cmd_response128_t s_resp,
  output fta_cmd_request32_t   m_req,
  input  fta_cmd_response32_t  chresp [CHANNELS]
);

  localparam int L   = WID / NWID;
  localparam int NB  = NWID / 8;
  localparam int LW  = (L > 1) ? $clog2(L) : 1;
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int AOW = $clog2(WID / 8);
  localparam int CW  = $clog2(TMO + 1);

  bridge_state_t       state, state_nx;
  fta_cmd_response32_t respo;

  logic            we_q;
  logic [4:0]      cmd_q;
  logic [1:0]      bte_q;
  logic [2:0]      cti_q;
  logic [TIDW-1:0] tid_q;
  logic [AW-1:0]   padr_q;
  logic [WID/8-1:0] sel_q;
  logic [WID-1:0]  data_q;
  logic [WID-1:0]  rdata_q;
  logic [L-1:0]    mask_q, acc_mask, enc_in;
  logic [LW-1:0]   lane_q, enc_lane;
  logic            enc_any;
  logic            err_q, rty_q;
  logic [3:0]      pri_q;
  logic [CW-1:0]   cnt_q;
  logic [NB-1:0]   lane_sel;
  logic [BW-1:0]   byte_idx;
  logic [AOW-1:0]  byte_off;
  logic            accept, hit, tmo;
  logic            unused_resp_bits;

  fta_respbuf #(.CHANNELS(CHANNELS)) u_respbuf (
    .chresp (chresp),
    .respo  (respo)
  );

  assign unused_resp_bits = ^{respo.next, respo.stall, respo.adr};

  for (genvar g = 0; g < L; g++) begin : g_mask
    assign acc_mask[g] = |s_req.sel[g*NB +: NB];
  end

  assign accept = (state == IDLE) && s_req.cyc && s_req.stb;
  assign hit    = (state == WAIT) && (respo.ack || respo.err || respo.rty) && (respo.tid == tid_q);
  assign tmo    = (cnt_q == CW'(TMO));

  // One encoder serves both acceptance (fresh mask) and lane retirement (mask minus current lane).
  always_comb begin
    enc_in = acc_mask;
    if (state != IDLE) begin
      enc_in = mask_q;
      enc_in[lane_q] = 1'b0;
    end
    enc_any  = |enc_in;
    enc_lane = '0;
    for (int k = L - 1; k >= 0; k--) begin
      if (enc_in[k]) enc_lane = LW'(k);
    end
  end

  always_comb begin
    lane_sel = sel_q[lane_q*NB +: NB];
    byte_idx = '0;
    for (int b = NB - 1; b >= 0; b--) begin
      if (lane_sel[b]) byte_idx = BW'(b);
    end
    byte_off = AOW'(lane_q * NB) + AOW'(byte_idx);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    m_req       = '0;
    m_req.padr  = '1;
    s_resp      = '0;
    case (state)
      IDLE: begin
        if (accept) state_nx = (acc_mask != '0) ? ISSUE : RESP;
      end
      ISSUE, WAIT: begin
        m_req.cyc   = 1'b1;
        m_req.stb   = (state == ISSUE);
        m_req.we    = we_q;
        m_req.cmd   = cmd_q;
        m_req.bte   = bte_q;
        m_req.cti   = cti_q;
        m_req.tid   = tid_q;
        m_req.sel   = lane_sel;
        m_req.data1 = data_q[lane_q*NWID +: NWID];
        m_req.padr  = {padr_q[AW-1:AOW], byte_off};
        s_resp.stall = 1'b1;
        if (state == ISSUE) state_nx = WAIT;
        else if (hit) state_nx = (respo.err || respo.rty || !enc_any) ? RESP : ISSUE;
        else if (tmo) state_nx = RESP;
      end
      RESP: begin
        s_resp.stall = 1'b1;
        s_resp.ack   = ~err_q & ~rty_q;
        s_resp.err   = err_q;
        s_resp.rty   = rty_q;
        s_resp.tid   = tid_q;
        s_resp.adr   = padr_q;
        s_resp.pri   = pri_q;
        s_resp.dat   = rdata_q;
        state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      cmd_q   <= '0;
      bte_q   <= '0;
      cti_q   <= '0;
      tid_q   <= '0;
      padr_q  <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      mask_q  <= '0;
      lane_q  <= '0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
      pri_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= s_req.we;
            cmd_q   <= s_req.cmd;
            bte_q   <= s_req.bte;
            cti_q   <= s_req.cti;
            tid_q   <= s_req.tid;
            padr_q  <= s_req.padr;
            sel_q   <= s_req.sel;
            data_q  <= s_req.data1;
            rdata_q <= '0;
            mask_q  <= acc_mask;
            lane_q  <= enc_lane;
            err_q   <= 1'b0;
            rty_q   <= 1'b0;
            pri_q   <= '0;
            cnt_q   <= '0;
          end
        end
        ISSUE: cnt_q <= CW'(1);
        WAIT: begin
          // A matching response beats a timeout expiring in the same cycle.
          if (hit) begin
            if (!we_q) rdata_q[lane_q*NWID +: NWID] <= respo.dat;
            err_q  <= err_q | respo.err;
            rty_q  <= rty_q | respo.rty;
            pri_q  <= respo.pri;
            mask_q <= enc_in;
            lane_q <= enc_lane;
          end else if (tmo) begin
            err_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bridge_wide_to_narrow_fta.sv
// Directed testbench for io_bridge_wide_to_narrow_fta: table of lane-split vectors
// plus hand-written timeout, wrong-tid and mid-transaction reset sequences.
module tb_io_bridge_wide_to_narrow_fta;
  import fta_bus_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  fta_cmd_request128_t  s_req;
  fta_cmd_response128_t s_resp;
  fta_cmd_request32_t   m_req;
  fta_cmd_response32_t  chresp [2];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0]  sel;
    logic         we;
    logic [127:0] data1;
    logic [31:0]  padr;
    logic [7:0]   tid;
    int           dly;
    int           ch;
    int           bad_beat;
    logic         bad_rty;
    logic [127:0] rd;
    int           exp_beats;
    logic [3:0]   exp_lanes;
    logic         exp_ack;
    logic         exp_err;
    logic         exp_rty;
    logic [127:0] exp_dat;
    logic [3:0]   exp_pri;
  } vec_t;

  vec_t vecs [6];

  io_bridge_wide_to_narrow_fta #(
    .WID(128), .NWID(32), .CHANNELS(2), .TMO(15)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .s_req  (s_req),
    .s_resp (s_resp),
    .m_req  (m_req),
    .chresp (chresp)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic fta_cmd_request32_t idleReq();
    fta_cmd_request32_t r;
    r = '0;
    r.padr = '1;
    return r;
  endfunction

  task automatic startReq(input logic [15:0] sel, input logic we, input logic [7:0] tid,
                          input logic [31:0] padr, input logic [127:0] data1);
    s_req       = '0;
    s_req.cyc   = 1'b1;
    s_req.stb   = 1'b1;
    s_req.we    = we;
    s_req.cmd   = 5'd1;
    s_req.tid   = tid;
    s_req.padr  = padr;
    s_req.sel   = sel;
    s_req.data1 = data1;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [3:0] rem;
    logic [3:0] lsel;
    logic       pend, done, bad;
    int         beats, cd, plane, pbeat, lane, lowb, done_cyc;
    rem = v.exp_lanes; beats = 0; pend = 1'b0; done = 1'b0;
    cd = 0; plane = 0; pbeat = 0; done_cyc = -1;
    startReq(v.sel, v.we, v.tid, v.padr, v.data1);
    for (int n = 1; n <= 100 && !done; n++) begin
      step();
      s_req.cyc = 1'b0;
      s_req.stb = 1'b0;
      chresp[0] = '0;
      chresp[1] = '0;
      if (pend) begin
        cd--;
        if (cd <= 0) begin
          bad = (pbeat == v.bad_beat);
          chresp[v.ch].ack = ~bad;
          chresp[v.ch].err = bad & ~v.bad_rty;
          chresp[v.ch].rty = bad & v.bad_rty;
          chresp[v.ch].tid = v.tid;
          chresp[v.ch].dat = bad ? 32'h0 : v.rd[plane*32 +: 32];
          chresp[v.ch].pri = 4'(5 + pbeat);
          pend = 1'b0;
        end
      end
      if (m_req.stb) begin
        lane = 0;
        for (int k = 3; k >= 0; k--) if (rem[k]) lane = k;
        lsel = v.sel[lane*4 +: 4];
        lowb = 0;
        for (int b = 3; b >= 0; b--) if (lsel[b]) lowb = b;
        checkOutput($sformatf("v%0d_b%0d_sel", idx, beats), m_req.sel, lsel);
        checkOutput($sformatf("v%0d_b%0d_padr", idx, beats), m_req.padr, {v.padr[31:4], 4'(lane*4 + lowb)});
        checkOutput($sformatf("v%0d_b%0d_data", idx, beats), m_req.data1, v.data1[lane*32 +: 32]);
        checkOutput($sformatf("v%0d_b%0d_we_cyc_stall", idx, beats), {m_req.we, m_req.cyc, s_resp.stall}, {v.we, 2'b11});
        rem[lane] = 1'b0;
        beats++;
        pend  = 1'b1;
        cd    = v.dly;
        plane = lane;
        pbeat = beats - 1;
      end
      if (s_resp.ack || s_resp.err || s_resp.rty) begin
        done = 1'b1;
        done_cyc = n;
        checkOutput($sformatf("v%0d_ack_err_rty", idx), {s_resp.ack, s_resp.err, s_resp.rty},
                    {v.exp_ack, v.exp_err, v.exp_rty});
        checkOutput($sformatf("v%0d_dat", idx), s_resp.dat, v.exp_dat);
        checkOutput($sformatf("v%0d_tid_adr", idx), {s_resp.tid, s_resp.adr}, {v.tid, v.padr});
        checkOutput($sformatf("v%0d_pri", idx), s_resp.pri, v.exp_pri);
        checkOutput($sformatf("v%0d_resp_m_idle", idx), m_req, idleReq());
      end
    end
    checkOutput($sformatf("v%0d_completed", idx), done, 1'b1);
    checkOutput($sformatf("v%0d_beats", idx), 32'(beats), 32'(v.exp_beats));
    checkOutput($sformatf("v%0d_latency", idx), 32'(done_cyc), 32'(1 + v.exp_beats * (v.dly + 1)));
    chresp[0] = '0;
    chresp[1] = '0;
    step();
    checkOutput($sformatf("v%0d_back_idle", idx), {s_resp.ack, s_resp.err, s_resp.stall, m_req.cyc}, 4'b0000);
  endtask

  initial begin
    int   got;
    logic seen;

    vecs[0] = '{sel:16'h00F0, we:1'b0, data1:128'h0, padr:32'h1000_0000, tid:8'h11, dly:2, ch:0,
                bad_beat:-1, bad_rty:1'b0, rd:128'h44444444_33333333_DEADBEEF_11111111,
                exp_beats:1, exp_lanes:4'b0010, exp_ack:1'b1, exp_err:1'b0, exp_rty:1'b0,
                exp_dat:128'h00000000_00000000_DEADBEEF_00000000, exp_pri:4'd5};
    vecs[1] = '{sel:16'hFFFF, we:1'b1, data1:128'h33333333_22222222_11111111_00000000,
                padr:32'h2000_0007, tid:8'h22, dly:1, ch:0, bad_beat:-1, bad_rty:1'b0,
                rd:128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, exp_beats:4, exp_lanes:4'b1111,
                exp_ack:1'b1, exp_err:1'b0, exp_rty:1'b0, exp_dat:128'h0, exp_pri:4'd8};
    vecs[2] = '{sel:16'h0F0F, we:1'b0, data1:128'h0, padr:32'h3000_0000, tid:8'h33, dly:1, ch:0,
                bad_beat:1, bad_rty:1'b0, rd:128'h00000000_77777777_00000000_0BADF00D,
                exp_beats:2, exp_lanes:4'b0101, exp_ack:1'b0, exp_err:1'b1, exp_rty:1'b0,
                exp_dat:128'h00000000_00000000_00000000_0BADF00D, exp_pri:4'd6};
    vecs[3] = '{sel:16'h0000, we:1'b0, data1:128'h0, padr:32'h3100_0000, tid:8'h3A, dly:1, ch:0,
                bad_beat:-1, bad_rty:1'b0, rd:128'h0, exp_beats:0, exp_lanes:4'b0000,
                exp_ack:1'b1, exp_err:1'b0, exp_rty:1'b0, exp_dat:128'h0, exp_pri:4'd0};
    vecs[4] = '{sel:16'h8400, we:1'b0, data1:128'h0, padr:32'h4000_00F3, tid:8'h44, dly:3, ch:1,
                bad_beat:-1, bad_rty:1'b0, rd:128'h12345678_CAFEF00D_99999999_88888888,
                exp_beats:2, exp_lanes:4'b1100, exp_ack:1'b1, exp_err:1'b0, exp_rty:1'b0,
                exp_dat:128'h12345678_CAFEF00D_00000000_00000000, exp_pri:4'd6};
    vecs[5] = '{sel:16'h00FF, we:1'b0, data1:128'h0, padr:32'h4100_0000, tid:8'h45, dly:1, ch:0,
                bad_beat:0, bad_rty:1'b1, rd:128'h0, exp_beats:1, exp_lanes:4'b0001,
                exp_ack:1'b0, exp_err:1'b0, exp_rty:1'b1, exp_dat:128'h0, exp_pri:4'd5};

    rst_i     = 1'b1;
    s_req     = '0;
    chresp[0] = '0;
    chresp[1] = '0;
    #12;
    checkOutput("reset_s_resp", s_resp, 256'h0);
    checkOutput("reset_m_req", m_req, idleReq());
    rst_i = 1'b0;
    step();
    checkOutput("idle_no_stall", s_resp.stall, 1'b0);

    for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

    // Timeout: no device response at all.
    startReq(16'h000F, 1'b0, 8'h50, 32'h5000_0000, '0);
    step();
    s_req.cyc = 1'b0;
    s_req.stb = 1'b0;
    checkOutput("tmo_issue_stb", m_req.stb, 1'b1);
    got = 0;
    for (int n = 1; n <= 40 && got == 0; n++) begin
      step();
      if (s_resp.ack || s_resp.err || s_resp.rty) begin
        got = n;
        checkOutput("tmo_ack_err_rty", {s_resp.ack, s_resp.err, s_resp.rty}, 3'b010);
        checkOutput("tmo_m_req_idle", m_req, idleReq());
      end
    end
    checkOutput("tmo_cycles_after_issue", 32'(got), 32'd16);
    step();

    // Wrong tid first, then the matching one.
    startReq(16'h00F0, 1'b0, 8'h55, 32'h5500_0010, '0);
    step();
    s_req.cyc = 1'b0;
    s_req.stb = 1'b0;
    got = 0;
    for (int n = 1; n <= 20 && got == 0; n++) begin
      step();
      chresp[0] = '0;
      if (n == 1) begin
        chresp[0].ack = 1'b1;
        chresp[0].tid = 8'h56;
        chresp[0].dat = 32'h11110000;
      end
      if (n == 3) begin
        chresp[0].ack = 1'b1;
        chresp[0].tid = 8'h55;
        chresp[0].dat = 32'hABCD0123;
        chresp[0].pri = 4'h9;
      end
      if (s_resp.ack || s_resp.err || s_resp.rty) begin
        got = n;
        checkOutput("tid_ack", {s_resp.ack, s_resp.err, s_resp.rty}, 3'b100);
        checkOutput("tid_value", s_resp.tid, 8'h55);
        checkOutput("tid_dat", s_resp.dat, 128'h00000000_00000000_ABCD0123_00000000);
        checkOutput("tid_pri", s_resp.pri, 4'h9);
      end
    end
    checkOutput("tid_resp_cycle", 32'(got), 32'd4);
    chresp[0] = '0;
    step();

    // Asynchronous reset while waiting on the first lane of a 4-lane read.
    startReq(16'hFFFF, 1'b0, 8'h66, 32'h6600_0000, '0);
    step();
    s_req.cyc = 1'b0;
    s_req.stb = 1'b0;
    step();
    step();
    checkOutput("rst_mid_in_wait", {m_req.cyc, m_req.stb}, 2'b10);
    #3 rst_i = 1'b1;
    #1;
    checkOutput("rst_mid_s_resp", s_resp, 256'h0);
    checkOutput("rst_mid_m_req", m_req, idleReq());
    #2 rst_i = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      step();
      if (s_resp.ack || s_resp.err || s_resp.rty || m_req.cyc) seen = 1'b1;
    end
    checkOutput("rst_mid_no_late_resp", seen, 1'b0);
    applyStimulus(vecs[0], 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
